// File: rtl/addsub_arbiter_if.sv
// Bundles the requester, datapath and response handshakes of the add/sub arbiter.
// master = controller side, slave = producers / datapath / consumer side.
interface addsub_arbiter_if #(parameter int W = 6);
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] au_a, au_b, au_s;
    logic         au_addsub, au_cout, au_ov;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_ov, rsp_id;
    logic [W-1:0] rsp_sum;

    modport master (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req0_ready, req1_ready,
        output au_a, au_b, au_addsub,
        input  au_s, au_cout, au_ov,
        output rsp_valid, rsp_sum, rsp_cout, rsp_ov, rsp_id,
        input  rsp_ready
    );

    modport slave (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req0_ready, req1_ready,
        input  au_a, au_b, au_addsub,
        output au_s, au_cout, au_ov,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_ov, rsp_id,
        output rsp_ready
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a shared W-bit add/sub datapath.
// Optional per-requester / overflow statistics counters under `ARB_STATS_EN.
module addsub_arbiter #(
    parameter int W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_arbiter_if.master  bus
`ifdef ARB_STATS_EN
    ,
    output logic [7:0]        stat_cnt0,
    output logic [7:0]        stat_cnt1,
    output logic [7:0]        stat_ovcnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic         r_last_grant;
    logic [W-1:0] r_a, r_b;
    logic         r_sub, r_id;
    logic         r_rsp_valid, r_rsp_cout, r_rsp_ov, r_rsp_id;
    logic [W-1:0] r_rsp_sum;

    logic [1:0]   w_req_vld;
    logic         w_grant_id, w_rdy0, w_rdy1, w_acc, w_rsp_hs;

    assign w_req_vld = {bus.req1_valid, bus.req0_valid};

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign w_grant_id = (&w_req_vld) ? ~r_last_grant : w_req_vld[1];
    assign w_rdy0     = (r_state == ST_IDLE) && w_req_vld[0] && !w_grant_id;
    assign w_rdy1     = (r_state == ST_IDLE) && w_req_vld[1] &&  w_grant_id;
    assign w_acc      = w_rdy0 || w_rdy1;
    assign w_rsp_hs   = (r_state == ST_RESP) && r_rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_acc) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_sum    <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_ov     <= 1'b0;
            r_rsp_id     <= 1'b0;
        end else begin
            if (w_acc) begin
                r_a          <= w_grant_id ? bus.req1_a   : bus.req0_a;
                r_b          <= w_grant_id ? bus.req1_b   : bus.req0_b;
                r_sub        <= w_grant_id ? bus.req1_sub : bus.req0_sub;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_sum   <= bus.au_s;
                r_rsp_cout  <= bus.au_cout;
                r_rsp_ov    <= bus.au_ov;
                r_rsp_id    <= r_id;
            end else if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Datapath operands come straight from the op registers, so they are stable through EXEC.
    assign bus.au_a       = r_a;
    assign bus.au_b       = r_b;
    assign bus.au_addsub  = r_sub;
    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_sum    = r_rsp_sum;
    assign bus.rsp_cout   = r_rsp_cout;
    assign bus.rsp_ov     = r_rsp_ov;
    assign bus.rsp_id     = r_rsp_id;

`ifdef ARB_STATS_EN
    logic [7:0] r_cnt0, r_cnt1, r_ovcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0  <= 8'd0;
            r_cnt1  <= 8'd0;
            r_ovcnt <= 8'd0;
        end else if (w_rsp_hs) begin
            if (!r_rsp_id && r_cnt0  != 8'hFF) r_cnt0  <= r_cnt0 + 8'd1;
            if ( r_rsp_id && r_cnt1  != 8'hFF) r_cnt1  <= r_cnt1 + 8'd1;
            if ( r_rsp_ov && r_ovcnt != 8'hFF) r_ovcnt <= r_ovcnt + 8'd1;
        end
    end

    assign stat_cnt0  = r_cnt0;
    assign stat_cnt1  = r_cnt1;
    assign stat_ovcnt = r_ovcnt;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural 6-bit ripple add/sub on the au_* ports.
// Build with +define+ARB_STATS_EN to also check the statistics counters.
module tb_addsub_arbiter;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    addsub_arbiter_if #(.W(W)) bus ();

`ifdef ARB_STATS_EN
    logic [7:0] stat_cnt0, stat_cnt1, stat_ovcnt;
`endif

    addsub_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef ARB_STATS_EN
        ,
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1),
        .stat_ovcnt (stat_ovcnt)
`endif
    );

    always #5 clk = ~clk;

    // External datapath: sub = A + ~B + 1, ov when operand signs agree and sum sign differs.
    logic [W-1:0] dp_bb;
    logic [W:0]   dp_full;
    assign dp_bb       = bus.au_addsub ? ~bus.au_b : bus.au_b;
    assign dp_full     = {1'b0, bus.au_a} + {1'b0, dp_bb} + {{W{1'b0}}, bus.au_addsub};
    assign bus.au_s    = dp_full[W-1:0];
    assign bus.au_cout = dp_full[W];
    assign bus.au_ov   = (bus.au_a[W-1] == dp_bb[W-1]) && (dp_full[W-1] != bus.au_a[W-1]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int rq, input logic v, input logic [W-1:0] a, b, input logic s);
        if (rq == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = s;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = s;
        end
    endtask

    // One transaction from IDLE with rsp_ready high; returns #1 after the edge that re-enters IDLE.
    task automatic run_op(input string tag, input int rq, input logic [W-1:0] a, b, input logic s,
                          input logic [W-1:0] es, input logic ec, eo);
        drive(rq, 1'b1, a, b, s);
        #1;
        chk({tag, "_rdy"}, (rq == 0) ? bus.req0_ready : bus.req1_ready, 1);
        tick();
        drive(rq, 1'b0, '0, '0, 1'b0);
        chk({tag, "_exec_vld"}, bus.rsp_valid, 0);
        chk({tag, "_au_a"}, bus.au_a, a);
        tick();
        chk({tag, "_vld"},  bus.rsp_valid, 1);
        chk({tag, "_sum"},  bus.rsp_sum, es);
        chk({tag, "_cout"}, bus.rsp_cout, ec);
        chk({tag, "_ov"},   bus.rsp_ov, eo);
        chk({tag, "_id"},   bus.rsp_id, rq[0]);
        tick();
        chk({tag, "_done"}, bus.rsp_valid, 0);
    endtask

    initial begin
        logic [W-1:0] hold_sum;
        int           gq[$];
        int           iq[$];

        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        chk("rst_vld",  bus.rsp_valid, 0);
        chk("rst_sum",  bus.rsp_sum, 0);
        chk("rst_au_a", bus.au_a, 0);
        chk("rst_rdy",  {bus.req1_ready, bus.req0_ready}, 0);
`ifdef ARB_STATS_EN
        chk("rst_stats", {stat_cnt0, stat_cnt1, stat_ovcnt}, 0);
`endif
        rst_n = 1'b1;
        tick();

        run_op("t1_add",  0, 6'h05, 6'h03, 1'b0, 6'h08, 1'b0, 1'b0);
        // 0x20 is -32 signed, so 16 - (-32) = 48 overflows the signed range
        run_op("t2_sub",  1, 6'h10, 6'h20, 1'b1, 6'h30, 1'b0, 1'b1);
        run_op("t3_ov",   0, 6'h1F, 6'h01, 1'b0, 6'h20, 1'b0, 1'b1);
        run_op("t3_wrap", 0, 6'h3F, 6'h01, 1'b0, 6'h00, 1'b1, 1'b0);

        // T5: stall the consumer with a competing request waiting
        bus.rsp_ready = 1'b0;
        drive(1, 1'b1, 6'h25, 6'h0A, 1'b0);
        tick();
        drive(1, 1'b0, '0, '0, 1'b0);
        drive(0, 1'b1, 6'h02, 6'h05, 1'b1);
        tick();
        chk("t5_vld", bus.rsp_valid, 1);
        hold_sum = bus.rsp_sum;
        chk("t5_sum", hold_sum, 6'h2F);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_vld", bus.rsp_valid, 1);
            chk("t5_hold_sum", bus.rsp_sum, hold_sum);
            chk("t5_hold_rdy", {bus.req1_ready, bus.req0_ready}, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("t5_release_vld", bus.rsp_valid, 0);
        chk("t5_idle_rdy0", bus.req0_ready, 1);
        drive(0, 1'b0, '0, '0, 1'b0);
        run_op("t5_next", 0, 6'h02, 6'h05, 1'b1, 6'h3D, 1'b0, 1'b0);

        // T6: reset while EXEC discards the transaction
        drive(1, 1'b1, 6'h04, 6'h01, 1'b0);
        tick();
        drive(1, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_vld", bus.rsp_valid, 0);
        chk("t6_au_a", bus.au_a, 0);
`ifdef ARB_STATS_EN
        chk("t6_stats", {stat_cnt0, stat_cnt1, stat_ovcnt}, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t6_no_rsp", bus.rsp_valid, 0);

        // T4: both requesters held valid; req0 must win first after reset
        drive(0, 1'b1, 6'h01, 6'h02, 1'b0);
        drive(1, 1'b1, 6'h1F, 6'h3F, 1'b1);
        #1;
        for (int c = 0; c < 12; c++) begin
            chk("t4_excl", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready) gq.push_back(0);
            if (bus.req1_ready) gq.push_back(1);
            if (bus.rsp_valid) begin
                iq.push_back(int'(bus.rsp_id));
                chk("t4_sum", bus.rsp_sum, bus.rsp_id ? 6'h20 : 6'h03);
                chk("t4_ov",  bus.rsp_ov,  bus.rsp_id ? 1 : 0);
            end
            tick();
        end
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        chk("t4_ngrant", gq.size(), 4);
        chk("t4_nrsp",   iq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t4_grant", (i < gq.size()) ? gq[i] : -1, i % 2);
            chk("t4_rspid", (i < iq.size()) ? iq[i] : -1, i % 2);
        end
`ifdef ARB_STATS_EN
        tick();
        chk("t4_cnt0",  stat_cnt0,  2);
        chk("t4_cnt1",  stat_cnt1,  2);
        chk("t4_ovcnt", stat_ovcnt, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
